// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and parameter defaults for the SPI master controller
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
  localparam int FRAME_BITS_DEF = 8;
  localparam int DIV_W_DEF = 8;
endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: frame handshake and status bus between host logic and the SPI master
interface spi_master_ctrl_if import spi_pkg::*; #(parameter int FRAME_BITS = FRAME_BITS_DEF);
  logic [FRAME_BITS-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [FRAME_BITS-1:0] rx_data;
  logic spif;
  logic spif_clr;
  modport master (output tx_data, tx_valid, spif_clr, input tx_ready, rx_data, spif);
  modport slave (input tx_data, tx_valid, spif_clr, output tx_ready, rx_data, spif);
endinterface

// File: rtl/spi_baud_gen.sv
// spi_baud_gen: emits one tick every div+1 enabled cycles, restarting whenever disabled
module spi_baud_gen import spi_pkg::*; #(parameter int DIV_W = DIV_W_DEF) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic [DIV_W-1:0] div,
  output logic tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == div;
  // count up to div then restart; all-ones div gives a full 2^DIV_W period
  always_ff @(posedge clk)
    cnt <= (rst || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master frame engine; define SPI_MODF_EN to add mode-fault detection
module spi_master_ctrl import spi_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input logic clk,
  input logic rst,
  input logic spe,
  input logic mstr,
  input logic cpol,
  input logic cpha,
  input logic ssoe,
  input logic lsbfe,
  input logic spie,
  input logic sptie,
  input logic [DIV_W-1:0] baud_div,
  spi_master_ctrl_if.slave bus,
  output logic sclk,
  output logic mosi,
  output logic ss_n,
  input logic miso,
  output logic irq
`ifdef SPI_MODF_EN
  ,
  input logic ss_in_n,
  input logic modfen,
  input logic modf_clr,
  output logic modf
`endif
);
  localparam int HW = $clog2(2 * FRAME_BITS);
  state_t state, nxt;
  logic cpol_l, cpha_l, lsbfe_l, ssoe_l, sclk_q, tick, accept, abort, flt, blk, mirq, lead, smp, shf, fin, rdy;
  logic [DIV_W-1:0] div_l;
  logic [FRAME_BITS-1:0] sh, rxs;
  logic [HW-1:0] hcnt;
`ifdef SPI_MODF_EN
  assign flt = mstr && modfen && !ssoe && !ss_in_n;
  assign blk = modf;
  assign mirq = spie && modf;
  // sticky mode fault, a new fault wins over a clear in the same cycle
  always_ff @(posedge clk)
    modf <= rst ? 1'b0 : flt || (modf && !modf_clr);
`else
  assign flt = 1'b0;
  assign blk = 1'b0;
  assign mirq = 1'b0;
`endif
  assign accept = bus.tx_valid && bus.tx_ready;
  assign abort = state != IDLE && (!spe || !mstr || flt);
  assign lead = !hcnt[0];
  assign smp = cpha_l ? !lead : lead;
  assign shf = cpha_l ? lead && hcnt != '0 : !lead;
  assign fin = state == DONE && tick && !abort;
  spi_baud_gen #(.DIV_W(DIV_W)) u_baud (.clk(clk), .rst(rst), .en(state != IDLE), .div(div_l), .tick(tick));
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // next-state: setup and done last one half-period, shift lasts 2*FRAME_BITS of them
  always_comb
    nxt = abort ? IDLE :
          state == IDLE ? (accept ? SETUP : IDLE) :
          state == SETUP ? (tick ? SHIFT : SETUP) :
          state == SHIFT ? (tick && hcnt == HW'(2 * FRAME_BITS - 1) ? DONE : SHIFT) :
          (tick ? IDLE : DONE);
  // pin and status outputs decoded from state and latched configuration
  always_comb begin
    rdy = state == IDLE && spe && mstr && !blk;
    bus.tx_ready = rdy;
    ss_n = !(state != IDLE && ssoe_l);
    sclk = state == SHIFT ? sclk_q : cpol_l;
    mosi = lsbfe_l ? sh[0] : sh[FRAME_BITS-1];
    irq = !rst && ((spie && bus.spif) || (sptie && rdy) || mirq);
  end
  // datapath: latch frame and config on accept, shift on half-period ticks, publish on done
  always_ff @(posedge clk)
    if (rst) begin
      {cpol_l, cpha_l, lsbfe_l, ssoe_l, sclk_q, bus.spif} <= '0;
      div_l <= '0;
      sh <= '0;
      rxs <= '0;
      hcnt <= '0;
      bus.rx_data <= '0;
    end else begin
      if (accept) begin
        {cpol_l, cpha_l, lsbfe_l, ssoe_l} <= {cpol, cpha, lsbfe, ssoe};
        div_l <= baud_div;
        sh <= bus.tx_data;
      end
      if (state == SHIFT && tick) begin
        hcnt <= hcnt + 1'b1;
        sclk_q <= !sclk_q;
        if (smp) rxs <= lsbfe_l ? {miso, rxs[FRAME_BITS-1:1]} : {rxs[FRAME_BITS-2:0], miso};
        if (shf) sh <= lsbfe_l ? sh >> 1 : sh << 1;
      end else if (state != SHIFT) begin
        hcnt <= '0;
        sclk_q <= cpol_l;
      end
      if (fin) bus.rx_data <= rxs;
      bus.spif <= fin || (bus.spif && !bus.spif_clr);
    end
endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of baud_div.
REQ-002 SHALL have parameter FRAME_BITS, default 8: bits per transfer.
REQ-003 SHALL use a single clock domain; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have ports spe, mstr, cpol, cpha, ssoe, lsbfe, spie and sptie, each input, 1: control bits from the control-register block.
REQ-007 SHALL have port baud_div, input, DIV_W: sclk half-period H = baud_div+1 clk cycles.
REQ-008 SHALL have port tx_data, input, FRAME_BITS: transmit frame.
REQ-009 SHALL have port tx_valid, input, 1: tx_data offered.
REQ-010 SHALL have port tx_ready, output, 1: controller can accept a frame.
REQ-011 SHALL have port rx_data, output, FRAME_BITS: last received frame.
REQ-012 SHALL have port spif, output, 1: sticky transfer-complete flag.
REQ-013 SHALL have port spif_clr, input, 1: clears spif.
REQ-014 SHALL have ports sclk, mosi and ss_n, each output, 1: SPI pins.
REQ-015 SHALL have port miso, input, 1: SPI serial data in.
REQ-016 SHALL have port irq, output, 1: interrupt request.

Function
REQ-017 SHALL implement states IDLE, SETUP, SHIFT and DONE.
- IDLE->SETUP on tx_valid&&tx_ready.
- SETUP->SHIFT after H cycles.
- SHIFT->DONE after 2*FRAME_BITS half-periods.
- DONE->IDLE after H cycles.
REQ-018 SHALL drive tx_ready = (state==IDLE) && spe && mstr.
REQ-019 SHALL latch tx_data, cpol, cpha, lsbfe, ssoe and baud_div on acceptance; later changes SHALL NOT affect the transfer in flight.
REQ-020 SHALL hold sclk at latched cpol in IDLE, SETUP and DONE, and toggle it at each half-period boundary in SHIFT.
REQ-021 SHALL drive ss_n low from the cycle after acceptance through DONE when ssoe=1; with ssoe=0, ss_n SHALL stay high.
REQ-022 SHALL shift MSB first when lsbfe=0 and LSB first when lsbfe=1; rx_data SHALL use the same bit order.
REQ-023 SHALL, with cpha=0, present the first bit on mosi at SETUP entry, sample miso on odd (leading) edges and shift mosi on even (trailing) edges.
REQ-024 SHALL, with cpha=1, shift mosi on leading edges and sample miso on trailing edges.
REQ-025 SHALL update rx_data and set spif on the last cycle of DONE; acceptance-to-spif latency is exactly 2*(FRAME_BITS+1)*H cycles.
REQ-026 SHALL give set priority over spif_clr when both occur in the same cycle.
REQ-027 SHALL drive irq = (spie && spif) || (sptie && tx_ready), plus the modf term of REQ-034 when that feature is compiled in.
REQ-028 SHALL, if spe or mstr drops mid-transfer, return to IDLE next cycle with sclk=cpol and ss_n=1, leave spif and rx_data unchanged, and discard the frame.
REQ-029 SHALL treat baud_div=0 as H=1 and baud_div=all-ones as H=2^DIV_W, with no wrap.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, sclk=0, mosi=0, ss_n=1, spif=0, rx_data=0, irq=0 and clear all counters.
REQ-031 SHALL let rst abort an in-flight transfer with no spif.

Configuration
REQ-032 SHALL make mode-fault detection present only when SPI_MODF_EN is defined.
REQ-033 SHALL, with SPI_MODF_EN defined, add ports ss_in_n (input, 1), modfen (input, 1), modf_clr (input, 1) and modf (output, 1).
REQ-034 SHALL, with SPI_MODF_EN defined, when mstr && modfen && !ssoe && ss_in_n==0 holds in any state:
- set modf (sticky; cleared by modf_clr, set wins).
- abort as in REQ-028.
- hold tx_ready low while modf=1.
- add spie && modf to irq.
REQ-035 SHALL, without SPI_MODF_EN, omit those ports and logic, with behaviour otherwise identical.

Structure
REQ-036 SHALL place the state enum, FRAME_BITS default and DIV_W default in shared package spi_pkg.
REQ-037 SHALL implement the half-period tick counter as sub-module spi_baud_gen (inputs clk, rst, en, div; output tick).

Verification
REQ-038 SHALL cover: mode 0 (cpol=0, cpha=0), lsbfe=0, baud_div=1, tx 0xA5, miso loops to mosi -> 8 rising sclk edges, mosi 1,0,1,0,0,1,0,1, rx_data=0xA5, spif high 36 cycles after acceptance.
REQ-039 SHALL cover: mode 3 (cpol=1, cpha=1), lsbfe=1, baud_div=0, tx 0x01, miso=1 constant -> sclk idles high, first mosi bit 1, rx_data=0xFF, spif after 18 cycles.
REQ-040 SHALL cover: spe dropped in the 5th half-period -> next cycle IDLE, ss_n=1, sclk=cpol, spif stays 0.
REQ-041 SHALL cover: spif_clr asserted on the spif-set cycle -> spif=1; spif_clr a cycle later -> spif=0; spie=1 -> irq tracks spif.
REQ-042 SHALL cover: tx_valid held during a transfer -> tx_ready=0 until IDLE, then back-to-back frame accepted on the first IDLE cycle.
REQ-043 SHALL cover, with SPI_MODF_EN: modfen=1, ssoe=0, ss_in_n pulled low mid-transfer -> modf=1, abort, tx_ready=0, irq=1 with spie=1.
